// File: rtl/fp_divsqrt_iter.sv
// Iterative radix-2 floating-point divide / square root with round-toward-zero.
// Special operands resolve in CHECK; normal operands take MAN_W+2 CALC cycles plus NORM.
module fp_divsqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 in_Clk,
    input  logic                 in_Rst,
    input  logic                 in_start,
    input  logic                 in_mode,
    input  logic [EXP_W+MAN_W:0] in_numA,
    input  logic [EXP_W+MAN_W:0] in_numB,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic                 out_valid,
    output logic                 out_stall
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int ITER = MAN_W + 2;
    localparam int EW   = EXP_W + 2;
    localparam int RW   = ITER + 4;
    localparam int CW   = $clog2(ITER);

    localparam logic signed [EW-1:0] BIAS       = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_ONE    = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO   = '0;
    localparam logic signed [EW-1:0] EXP_ALL1_S = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES   = '1;
    localparam logic [EXP_W-1:0]     EXP_MAXF   = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0]         QNAN       = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CALC, S_NORM, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [W-1:0]          r_a, r_b, r_result;
    logic                  r_mode, r_sign;
    logic signed [EW-1:0]  r_exp;
    logic [RW-1:0]         r_rem;
    logic [MAN_W:0]        r_den;
    logic [2*ITER-1:0]     r_rad;
    logic [ITER-1:0]       r_q;
    logic [CW-1:0]         r_cnt;

    logic                  w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_na, w_nb;
    logic [EXP_W-1:0]      w_ea, w_eb;
    logic [MAN_W-1:0]      w_fa, w_fb;
    logic                  w_special;
    logic [W-1:0]          w_spec_res, w_norm_res;
    logic signed [EW-1:0]  w_ea_x, w_eb_x, w_div_exp, w_sq_unb, w_sq_exp, w_nexp;
    logic [MAN_W+1:0]      w_sq_man;
    logic [RW-1:0]         w_rem_sh, w_trial, w_rem_red;
    logic                  w_ge;
    logic [MAN_W-1:0]      w_nfrac;

    assign w_sa = r_a[W-1];
    assign w_sb = r_b[W-1];
    assign w_ea = r_a[W-2 -: EXP_W];
    assign w_eb = r_b[W-2 -: EXP_W];
    assign w_fa = r_a[MAN_W-1:0];
    assign w_fb = r_b[MAN_W-1:0];
    // A zero exponent field counts as zero, which also flushes subnormals
    assign w_za = (w_ea == '0);
    assign w_zb = (w_eb == '0);
    assign w_ia = (w_ea == EXP_ONES) && (w_fa == '0);
    assign w_ib = (w_eb == EXP_ONES) && (w_fb == '0);
    assign w_na = (w_ea == EXP_ONES) && (w_fa != '0);
    assign w_nb = (w_eb == EXP_ONES) && (w_fb != '0);

    always_comb begin
        w_special  = 1'b0;
        w_spec_res = '0;
        if (r_mode) begin
            if (w_na || (w_sa && !w_za)) begin
                w_special  = 1'b1;
                w_spec_res = QNAN;
            end else if (w_za) begin
                w_special  = 1'b1;
                w_spec_res = {w_sa, {(W-1){1'b0}}};
            end else if (w_ia) begin
                w_special  = 1'b1;
                w_spec_res = {1'b0, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else begin
            if (w_na || w_nb || (w_za && w_zb) || (w_ia && w_ib)) begin
                w_special  = 1'b1;
                w_spec_res = QNAN;
            end else if (w_ia || w_zb) begin
                w_special  = 1'b1;
                w_spec_res = {w_sa ^ w_sb, EXP_ONES, {MAN_W{1'b0}}};
            end else if (w_ib || w_za) begin
                w_special  = 1'b1;
                w_spec_res = {w_sa ^ w_sb, {(W-1){1'b0}}};
            end
        end
    end

    assign w_ea_x    = $signed({2'b00, w_ea});
    assign w_eb_x    = $signed({2'b00, w_eb});
    assign w_div_exp = w_ea_x - w_eb_x + BIAS;
    assign w_sq_unb  = w_ea_x - BIAS;
    // Odd exponent: significand doubles; the floor shift absorbs the decrement
    assign w_sq_exp  = (w_sq_unb >>> 1) + BIAS;
    assign w_sq_man  = w_sq_unb[0] ? {1'b1, w_fa, 1'b0} : {2'b01, w_fa};

    assign w_rem_sh  = r_mode ? {r_rem[RW-3:0], r_rad[2*ITER-1 -: 2]} : r_rem;
    assign w_trial   = r_mode ? {2'b00, r_q, 2'b01} : {{(RW-MAN_W-1){1'b0}}, r_den};
    assign w_ge      = (w_rem_sh >= w_trial);
    assign w_rem_red = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;

    assign w_nexp    = r_q[ITER-1] ? r_exp : (r_exp - EXP_ONE);
    assign w_nfrac   = r_q[ITER-1] ? r_q[ITER-2:1] : r_q[ITER-3:0];

    always_comb begin
        w_norm_res = {r_sign, w_nexp[EXP_W-1:0], w_nfrac};
        if (w_nexp >= EXP_ALL1_S) begin
            w_norm_res = {r_sign, EXP_MAXF, {MAN_W{1'b1}}};
        end else if (w_nexp <= EXP_ZERO) begin
            w_norm_res = {r_sign, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_stall   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (in_start) w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_result <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_rem    <= '0;
            r_den    <= '0;
            r_rad    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_start) begin
                        r_a    <= in_numA;
                        r_b    <= in_numB;
                        r_mode <= in_mode;
                    end
                end
                S_CHECK: begin
                    r_cnt <= CW'(ITER - 1);
                    r_q   <= '0;
                    if (w_special) r_result <= w_spec_res;
                    if (r_mode) begin
                        r_sign <= 1'b0;
                        r_exp  <= w_sq_exp;
                        r_rem  <= '0;
                        r_rad  <= {w_sq_man, {(MAN_W+2){1'b0}}};
                    end else begin
                        r_sign <= w_sa ^ w_sb;
                        r_exp  <= w_div_exp;
                        r_rem  <= {{(RW-MAN_W-1){1'b0}}, 1'b1, w_fa};
                        r_den  <= {1'b1, w_fb};
                    end
                end
                S_CALC: begin
                    r_q   <= {r_q[ITER-2:0], w_ge};
                    r_rem <= r_mode ? w_rem_red : (w_rem_red << 1);
                    r_rad <= r_rad << 2;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_NORM:  r_result <= w_norm_res;
                default: ;
            endcase
        end
    end

    assign out_result = r_result;

endmodule

// File: doc/fp_divsqrt_iter.md
Name: fp_divsqrt_iter

Overview:
- Parametrised iterative floating-point divide/square-root unit; the next generation of the FPU's single-precision divider path.
- Adds FSQRT.S, which the current FPU returns as zero.
- Sits beside the combinational add/sub/mul datapaths; the FPU top drives start/mode and muxes out_result when out_valid.
- One radix-2 digit per cycle; exponent and mantissa widths are generic, so one RTL serves binary32 and reduced formats.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W

Ports:
in_Clk  input  1  clock, rising edge
in_Rst  input  1  synchronous reset, active-high
in_start  input  1  start pulse; sampled only in IDLE
in_mode  input  1  0 = divide in_numA/in_numB, 1 = sqrt(in_numA), in_numB ignored
in_numA  input  W  operand A, IEEE bit pattern
in_numB  input  W  operand B, IEEE bit pattern
out_result  output  W  result bit pattern; held stable until next accepted start
out_valid  output  1  one-cycle pulse when out_result is new
out_stall  output  1  high whenever state != IDLE

Behaviour:
- Reset (in_Rst=1 at an edge): state=IDLE, out_result=0, out_valid=0, out_stall=0.
  - Reset aborts any operation in progress; no out_valid is produced for it.
- Operand capture:
  - in_start=1 in IDLE registers operands and mode at that edge.
  - in_start in any other state is ignored; no queuing.
- States: IDLE -> (start) CHECK -> CALC or DONE; CALC -> NORM after ITER=MAN_W+2 cycles; NORM -> DONE; DONE -> IDLE.
- DONE:
  - out_valid=1 and out_result updated for exactly one cycle.
  - out_stall drops the cycle after DONE.
- CHECK resolves special cases directly to DONE; total latency start-edge to out_valid = 2 cycles. Subnormal inputs are flushed to signed zero before checks. Cases:
  - NaN operand -> canonical NaN {0, all-ones exp, 1, zeros}. Binary32: 0x7FC00000.
  - div: 0/0 or inf/inf -> canonical NaN.
  - div: x/0 (x finite nonzero) -> signed infinity, sign = sA^sB.
  - div: inf/x -> signed infinity; x/inf -> signed zero; 0/x -> signed zero.
  - sqrt: -0 -> -0; +0 -> +0; +inf -> +inf; any negative nonzero (including -inf) -> canonical NaN.
- Normal path latency: start-edge to out_valid = ITER+3 = MAN_W+5 cycles (28 for binary32).
- Divide:
  - sign = sA^sB.
  - exp = eA-eB+bias, computed in EXP_W+2-bit signed arithmetic.
  - Restoring division of {1,fracA} by {1,fracB}, one quotient bit per CALC cycle, ITER bits total.
- Sqrt:
  - If the unbiased exponent is odd, the significand is shifted left 1 and the exponent decremented.
  - Result exp = (unbiased>>1)+bias (arithmetic shift).
  - Restoring digit-by-digit root, one bit per CALC cycle.
- NORM:
  - If the quotient MSB = 0 (div case <1), shift left 1 and decrement exp.
  - Rounding is round-toward-zero: extra bits are truncated.
- NORM exponent range, on the final biased exp:
  - >= all-ones: largest finite magnitude with the result sign (RTZ overflow).
  - <= 0: signed zero (no subnormal output).
- A start in the same cycle as DONE is ignored (state != IDLE).
- A start on the cycle after DONE is accepted.

Test Plan:
- Divide: start, mode=0, A=0x40C00000 (6.0), B=0x40000000 (2.0) -> out_stall high 28 cycles; out_valid pulse on cycle 28 with out_result=0x40400000.
- Divide, RTZ: A=0x3F800000, B=0x40400000 (1/3) -> 0x3EAAAAAA (not 0x3EAAAAAB).
- Sqrt: mode=1, A=0x40000000 -> 0x3FB504F3.
  - A=0x40800000 (4.0) -> 0x40000000.
  - A=0x41100000 (9.0, odd exponent path) -> 0x40400000.
- Specials, each with out_valid 2 cycles after start:
  - 1.0/0.0 -> 0x7F800000.
  - -1.0/0.0 -> 0xFF800000.
  - 0/0 -> 0x7FC00000.
  - sqrt(0xC0800000) -> 0x7FC00000.
  - sqrt(0x80000000) -> 0x80000000.
- Busy/reset:
  - A second start with different operands 5 cycles into 6.0/2.0 -> ignored; result still 0x40400000 at cycle 28.
  - in_Rst=1 at cycle 10 of an operation -> next cycle out_stall=0, out_result=0; no out_valid.
  - New start right after reset completes normally.
- Range: 0x7F000000/0x3F000000 (overflow) -> 0x7F7FFFFF.
  - 0x00800000/0x40000000 (underflow) -> 0x00000000.
